// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: PC / stage-register load and flush enables from memory waits, load-use and mispredicts.
// Optional perf counters under HAZARD_PERF_CNT_EN (stall_cyc_o, flush_cnt_o).
module pipeline_hazard_ctrl #(
  parameter int REG_IDX_W = 5,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req_i,
  input  logic                 imem_resp_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_resp_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_mem_read_i,
  input  logic                 ex_mispredict_i,
  output logic                 pc_load_o,
  output logic                 if_id_load_o,
  output logic                 id_ex_load_o,
  output logic                 ex_mem_load_o,
  output logic                 mem_wb_load_o,
  output logic                 if_id_flush_o,
  output logic                 id_ex_flush_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0]     stall_cyc_o,
  output logic [CNT_W-1:0]     flush_cnt_o,
`endif
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    IWAIT = 2'b01,
    DWAIT = 2'b10,
    KILL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic dstall, istall, lu;
  logic pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_fl, id_ex_fl;
  logic mp_take;

  assign dstall = dmem_req_i & ~dmem_resp_i;
  assign istall = if_req_i & ~imem_resp_i;
  assign lu     = ex_mem_read_i & (ex_rd_i != '0) &
                  ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

  always_comb begin
    pc_ld     = 1'b0;
    if_id_ld  = 1'b0;
    id_ex_ld  = 1'b0;
    ex_mem_ld = 1'b0;
    mem_wb_ld = 1'b0;
    if_id_fl  = 1'b0;
    id_ex_fl  = 1'b0;
    mp_take   = 1'b0;
    state_d   = state_q;
    if (state_q == KILL) begin
      // Stale fetch still in flight: IF/ID keeps taking bubbles until it returns.
      if (!dstall) begin
        if_id_ld  = 1'b1;
        if_id_fl  = 1'b1;
        id_ex_ld  = 1'b1;
        ex_mem_ld = 1'b1;
        mem_wb_ld = 1'b1;
        pc_ld     = imem_resp_i;
        if (imem_resp_i) state_d = RUN;
      end
    end else if (dstall) begin
      // Keep tracking an outstanding fetch across a data wait.
      state_d = (state_q == IWAIT && !imem_resp_i) ? IWAIT : DWAIT;
    end else begin
      id_ex_ld  = 1'b1;
      ex_mem_ld = 1'b1;
      mem_wb_ld = 1'b1;
      if (ex_mispredict_i) begin
        pc_ld    = 1'b1;
        if_id_ld = 1'b1;
        if_id_fl = 1'b1;
        id_ex_fl = 1'b1;
        mp_take  = 1'b1;
        state_d  = istall ? KILL : RUN;
      end else if (lu) begin
        id_ex_fl = 1'b1;
        state_d  = istall ? IWAIT : RUN;
      end else if (istall) begin
        if_id_ld = 1'b1;
        if_id_fl = 1'b1;
        state_d  = IWAIT;
      end else begin
        pc_ld    = 1'b1;
        if_id_ld = 1'b1;
        state_d  = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign pc_load_o     = pc_ld & ~rst;
  assign if_id_load_o  = if_id_ld & ~rst;
  assign id_ex_load_o  = id_ex_ld & ~rst;
  assign ex_mem_load_o = ex_mem_ld & ~rst;
  assign mem_wb_load_o = mem_wb_ld & ~rst;
  assign if_id_flush_o = if_id_fl & ~rst;
  assign id_ex_flush_o = id_ex_fl & ~rst;
  assign state_o       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_ld && stall_cyc_q != '1) stall_cyc_d = stall_cyc_q + 1'b1;
    if (mp_take && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cyc_o = stall_cyc_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle vector table from RUN plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       if_req, imem_resp, dmem_req, dmem_resp;
  logic [4:0] rs1, rs2, rd;
  logic       mem_read, mp;
  logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush;
  logic [1:0] state;
  logic [6:0] outs;
`ifdef HAZARD_PERF_CNT_EN
  logic [3:0] stall_cyc, flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .REG_IDX_W(5)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .imem_resp_i(imem_resp),
    .dmem_req_i(dmem_req), .dmem_resp_i(dmem_resp),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .ex_rd_i(rd),
    .ex_mem_read_i(mem_read), .ex_mispredict_i(mp),
    .pc_load_o(pc_load), .if_id_load_o(if_id_load), .id_ex_load_o(id_ex_load),
    .ex_mem_load_o(ex_mem_load), .mem_wb_load_o(mem_wb_load),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cyc_o(stall_cyc), .flush_cnt_o(flush_cnt),
`endif
    .state_o(state)
  );

  // {pc, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld, if_id_fl, id_ex_fl}
  assign outs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load, if_id_flush, id_ex_flush};

  typedef struct {
    string      name;
    logic       if_req, imem_resp, dmem_req, dmem_resp;
    logic [4:0] rs1, rs2, rd;
    logic       mem_read, mp;
    logic [6:0] exp_out;
    logic [1:0] exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, logic ir, logic irs, logic dr, logic drs,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] d, logic mr, logic m,
                              logic [6:0] eo, logic [1:0] es);
    vec_t v;
    v.name = nm; v.if_req = ir; v.imem_resp = irs; v.dmem_req = dr; v.dmem_resp = drs;
    v.rs1 = r1; v.rs2 = r2; v.rd = d; v.mem_read = mr; v.mp = m;
    v.exp_out = eo; v.exp_st = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic irs, input logic dr, input logic drs,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                       input logic mr, input logic m);
    if_req = ir; imem_resp = irs; dmem_req = dr; dmem_resp = drs;
    rs1 = r1; rs2 = r2; rd = d; mem_read = mr; mp = m;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs checked mid-cycle, state after the next edge.
  task automatic cyc(input string nm, input logic [6:0] eo, input logic [1:0] es);
    #2;
    chk({nm, "_out"}, {25'd0, outs}, {25'd0, eo});
    @(posedge clk);
    #1;
    chk({nm, "_st"}, {30'd0, state}, {30'd0, es});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    #2;
    chk("rst_out", {25'd0, outs}, 32'd0);
    chk("rst_st", {30'd0, state}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    vecs.push_back(mk("none",        0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, 7'b1111100, 2'b00));
    vecs.push_back(mk("lu_rs1",      0,0,0,0, 5'd5, 5'd1, 5'd5, 1,0, 7'b0011101, 2'b00));
    vecs.push_back(mk("lu_rs2",      0,0,0,0, 5'd3, 5'd7, 5'd7, 1,0, 7'b0011101, 2'b00));
    vecs.push_back(mk("lu_rd0",      0,0,0,0, 5'd0, 5'd0, 5'd0, 1,0, 7'b1111100, 2'b00));
    vecs.push_back(mk("no_load",     0,0,0,0, 5'd5, 5'd5, 5'd5, 0,0, 7'b1111100, 2'b00));
    vecs.push_back(mk("istall",      1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, 7'b0111110, 2'b01));
    vecs.push_back(mk("ifetch_hit",  1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0, 7'b1111100, 2'b00));
    vecs.push_back(mk("dstall",      0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, 7'b0000000, 2'b10));
    vecs.push_back(mk("dmem_hit",    0,0,1,1, 5'd0, 5'd0, 5'd0, 0,0, 7'b1111100, 2'b00));
    vecs.push_back(mk("mp",          0,0,0,0, 5'd0, 5'd0, 5'd0, 0,1, 7'b1111111, 2'b00));
    vecs.push_back(mk("mp_istall",   1,0,0,0, 5'd0, 5'd0, 5'd0, 0,1, 7'b1111111, 2'b11));
    vecs.push_back(mk("mp_lu",       0,0,0,0, 5'd9, 5'd0, 5'd9, 1,1, 7'b1111111, 2'b00));
    vecs.push_back(mk("lu_istall",   1,0,0,0, 5'd4, 5'd0, 5'd4, 1,0, 7'b0011101, 2'b01));
    vecs.push_back(mk("dstall_mp",   0,0,1,0, 5'd0, 5'd0, 5'd0, 0,1, 7'b0000000, 2'b10));

    foreach (vecs[i]) begin
      do_reset();
      drive(vecs[i].if_req, vecs[i].imem_resp, vecs[i].dmem_req, vecs[i].dmem_resp,
            vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mem_read, vecs[i].mp);
      cyc(vecs[i].name, vecs[i].exp_out, vecs[i].exp_st);
    end

    // Reset pulse while a fetch miss is tracked
    do_reset();
    drive(1,0,0,0, 5'd0,5'd0,5'd0, 0,0);
    cyc("pre_rst", 7'b0111110, 2'b01);
    rst = 1'b1;
    #2;
    chk("midrst_out", {25'd0, outs}, 32'd0);
    chk("midrst_st", {30'd0, state}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    cyc("post_rst", 7'b1111100, 2'b00);

    // Load-use inserts exactly one bubble
    do_reset();
    drive(0,0,0,0, 5'd5,5'd0,5'd5, 1,0);
    cyc("lu1", 7'b0011101, 2'b00);
    idle();
    cyc("lu2", 7'b1111100, 2'b00);

    // Data miss: three frozen cycles, response in the fourth
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0,0,1,0, 5'd0,5'd0,5'd0, 0,0);
      cyc("dmiss", 7'b0000000, 2'b10);
    end
    drive(0,0,1,1, 5'd0,5'd0,5'd0, 0,0);
    cyc("dmiss_resp", 7'b1111100, 2'b00);

    // Mispredict deferred behind a data miss
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0,0,1,0, 5'd0,5'd0,5'd0, 0,1);
      cyc("mpd_hold", 7'b0000000, 2'b10);
    end
    drive(0,0,1,1, 5'd0,5'd0,5'd0, 0,1);
    cyc("mpd_flush", 7'b1111111, 2'b00);
    idle();
    cyc("mpd_after", 7'b1111100, 2'b00);

    // Mispredict with fetch outstanding, stale response squashed 3 cycles later
    do_reset();
    drive(1,0,0,0, 5'd0,5'd0,5'd0, 0,1);
    cyc("kill_enter", 7'b1111111, 2'b11);
    drive(1,0,0,0, 5'd0,5'd0,5'd0, 0,0);
    cyc("kill_wait", 7'b0111110, 2'b11);
    drive(1,0,1,0, 5'd0,5'd0,5'd0, 0,0);
    cyc("kill_dstall", 7'b0000000, 2'b11);
    drive(1,1,0,0, 5'd0,5'd0,5'd0, 0,0);
    cyc("kill_resp", 7'b1111110, 2'b00);

    // Mispredict from IWAIT
    do_reset();
    drive(1,0,0,0, 5'd0,5'd0,5'd0, 0,0);
    cyc("iw_enter", 7'b0111110, 2'b01);
    drive(1,0,0,0, 5'd0,5'd0,5'd0, 0,1);
    cyc("iw_mp", 7'b1111111, 2'b11);
    drive(1,1,0,0, 5'd0,5'd0,5'd0, 0,0);
    cyc("iw_resp", 7'b1111110, 2'b00);

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    chk("perf_rst_stall", {28'd0, stall_cyc}, 32'd0);
    chk("perf_rst_flush", {28'd0, flush_cnt}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(0,0,0,0, 5'd0,5'd0,5'd0, 0,1);
      cyc("perf_mp", 7'b1111111, 2'b00);
    end
    chk("perf_flush2", {28'd0, flush_cnt}, 32'd2);
    chk("perf_stall0", {28'd0, stall_cyc}, 32'd0);
    drive(1,0,0,0, 5'd0,5'd0,5'd0, 0,0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
    end
    chk("perf_stall_sat", {28'd0, stall_cyc}, 32'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
